blk_lock: RTL and testbench

BLK_LOCK -- requirements
Module: blk_lock

---
 rtl/blk_lock_pkg.sv | 22 ++
 rtl/blk_lock_if.sv | 12 +
 rtl/blk_lock_sat_cnt.sv | 23 ++
 rtl/blk_lock.sv | 149 ++++++++++++++
 tb/tb_blk_lock.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/blk_lock_pkg.sv
// Shared definitions for the 66b/64b block-lock slice: sync-header codes,
// lock FSM states and default lock parameters.
package blk_lock_pkg;

  localparam logic [1:0] SH_CTRL = 2'b01;
  localparam logic [1:0] SH_DATA = 2'b10;

  localparam int LOCK_CNT_DEF  = 64;
  localparam int BAD_MAX_DEF   = 16;
  localparam int SLIP_WAIT_DEF = 4;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    SLIP_WT = 2'd1,
    LOCKED  = 2'd2
  } blk_lock_state_e;

  function automatic logic sh_valid(input logic [1:0] sh);
    return (sh == SH_CTRL) || (sh == SH_DATA);
  endfunction

endpackage

// File: rtl/blk_lock_if.sv
// 66-bit block stream (payload, sync header, qualifier) between gearbox,
// block-lock and downstream consumers.
interface blk_lock_if;

  logic [63:0] dat;
  logic [1:0]  sh;
  logic        val;

  modport master (output dat, output sh, output val);
  modport slave  (input  dat, input  sh, input  val);

endinterface

// File: rtl/blk_lock_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_cnt #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/blk_lock.sv
// 66b/64b block-lock: hunts for sync-header alignment by slipping the gearbox,
// holds lock over bad-header windows, and forwards the aligned block stream.
module blk_lock
  import blk_lock_pkg::*;
#(
  parameter int LOCK_CNT  = LOCK_CNT_DEF,
  parameter int BAD_MAX   = BAD_MAX_DEF,
  parameter int SLIP_WAIT = SLIP_WAIT_DEF
) (
  input  logic             RXCLK,
  input  logic             RXRST_N,
  blk_lock_if.slave        rx,
  blk_lock_if.master       tx,
  input  logic             CNT_CLR,
  output logic             SLIP,
  output logic             RX_SYNC,
  output logic [15:0]      HDR_ERR_CNT,
  output logic [7:0]       LOCK_LOSS_CNT
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int BW = $clog2(BAD_MAX + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  // Compare against the pre-increment value so the counters never need the extra code.
  localparam logic [GW-1:0] GOOD_LAST = GW'(LOCK_CNT - 1);
  localparam logic [BW-1:0] BAD_LAST  = BW'(BAD_MAX - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(SLIP_WAIT - 1);

  blk_lock_state_e state_q, state_d;
  logic [GW-1:0]   good_q, good_d;
  logic [GW-1:0]   win_q, win_d;
  logic [BW-1:0]   bad_q, bad_d;
  logic [SW-1:0]   wait_q, wait_d;
  logic            slip_d;
  logic            hdr_inc;
  logic            loss_inc;
  logic            hdr_bad;

  assign hdr_bad = !sh_valid(rx.sh);

  always_ff @(posedge RXCLK) begin
    if (!RXRST_N) begin
      state_q <= HUNT;
      good_q  <= '0;
      win_q   <= '0;
      bad_q   <= '0;
      wait_q  <= '0;
      SLIP    <= 1'b0;
      tx.dat  <= '0;
      tx.sh   <= '0;
      tx.val  <= 1'b0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      win_q   <= win_d;
      bad_q   <= bad_d;
      wait_q  <= wait_d;
      SLIP    <= slip_d;
      tx.dat  <= rx.dat;
      tx.sh   <= rx.sh;
      tx.val  <= rx.val && (state_q == LOCKED);
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    win_d    = win_q;
    bad_d    = bad_q;
    wait_d   = wait_q;
    slip_d   = 1'b0;
    hdr_inc  = 1'b0;
    loss_inc = 1'b0;

    if (rx.val) begin
      unique case (state_q)
        HUNT: begin
          if (!hdr_bad) begin
            if (good_q == GOOD_LAST) begin
              state_d = LOCKED;
              good_d  = '0;
              win_d   = '0;
              bad_d   = '0;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            state_d = SLIP_WT;
            slip_d  = 1'b1;
            good_d  = '0;
            wait_d  = '0;
          end
        end

        SLIP_WT: begin
          if (wait_q == WAIT_LAST) begin
            state_d = HUNT;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end

        LOCKED: begin
          hdr_inc = hdr_bad;
          // Unlock is checked first so it wins when it lands on the window's last block.
          if (hdr_bad && (bad_q == BAD_LAST)) begin
            state_d  = SLIP_WT;
            slip_d   = 1'b1;
            loss_inc = 1'b1;
            good_d   = '0;
            win_d    = '0;
            bad_d    = '0;
            wait_d   = '0;
          end else if (win_q == GOOD_LAST) begin
            win_d = '0;
            bad_d = '0;
          end else begin
            win_d = win_q + 1'b1;
            bad_d = bad_q + BW'(hdr_bad);
          end
        end

        default: state_d = HUNT;
      endcase
    end
  end

  assign RX_SYNC = (state_q == LOCKED);

  sat_cnt #(.WIDTH(16)) u_hdr_err_cnt (
    .clk   (RXCLK),
    .rst_n (RXRST_N),
    .inc   (hdr_inc),
    .clr   (CNT_CLR),
    .cnt   (HDR_ERR_CNT)
  );

  sat_cnt #(.WIDTH(8)) u_lock_loss_cnt (
    .clk   (RXCLK),
    .rst_n (RXRST_N),
    .inc   (loss_inc),
    .clr   (CNT_CLR),
    .cnt   (LOCK_LOSS_CNT)
  );

endmodule

// File: tb/tb_blk_lock.sv
// Directed bench for blk_lock: acquisition, slip/hunt, window unlock,
// RX_VAL gaps, reset mid-lock and counter saturation/clear.
module tb_blk_lock;
  import blk_lock_pkg::*;

  localparam logic [1:0] SH_Z = 2'b00;
  localparam logic [1:0] SH_O = 2'b11;

  logic        RXCLK = 1'b0;
  logic        RXRST_N;
  logic        cnt_clr, cnt_clr2;
  logic        slip, rx_sync, slip2, rx_sync2;
  logic [15:0] hdr_err_cnt, hdr_err_cnt2;
  logic [7:0]  lock_loss_cnt, lock_loss_cnt2;

  int total = 0;
  int bad   = 0;
  int slip_pulses = 0;
  int slip_wide   = 0;
  logic slip_prev = 1'b0;

  blk_lock_if rx_if ();
  blk_lock_if tx_if ();
  blk_lock_if rx2_if ();
  blk_lock_if tx2_if ();

  always #5 RXCLK = ~RXCLK;

  blk_lock dut (
    .RXCLK         (RXCLK),
    .RXRST_N       (RXRST_N),
    .rx            (rx_if),
    .tx            (tx_if),
    .CNT_CLR       (cnt_clr),
    .SLIP          (slip),
    .RX_SYNC       (rx_sync),
    .HDR_ERR_CNT   (hdr_err_cnt),
    .LOCK_LOSS_CNT (lock_loss_cnt)
  );

  // One-block windows with BAD_MAX above the window: every bad header counts, lock never drops.
  blk_lock #(.LOCK_CNT(1), .BAD_MAX(2), .SLIP_WAIT(4)) dut_sat (
    .RXCLK         (RXCLK),
    .RXRST_N       (RXRST_N),
    .rx            (rx2_if),
    .tx            (tx2_if),
    .CNT_CLR       (cnt_clr2),
    .SLIP          (slip2),
    .RX_SYNC       (rx_sync2),
    .HDR_ERR_CNT   (hdr_err_cnt2),
    .LOCK_LOSS_CNT (lock_loss_cnt2)
  );

  always @(negedge RXCLK) begin
    if (slip) slip_pulses++;
    if (slip && slip_prev) slip_wide++;
    slip_prev = slip;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge RXCLK);
    #1;
  endtask

  task automatic blk(input logic [1:0] sh, input logic val, input logic [63:0] dat = 64'h0);
    rx_if.sh  = sh;
    rx_if.val = val;
    rx_if.dat = dat;
    step();
  endtask

  task automatic good_n(input int n);
    for (int i = 0; i < n; i++) blk(SH_CTRL, 1'b1, {32'hA5A5_0000, 32'(i)});
  endtask

  task automatic bad_n(input int n);
    for (int i = 0; i < n; i++) blk(SH_O, 1'b1, 64'h0);
  endtask

  task automatic do_reset();
    RXRST_N   = 1'b0;
    cnt_clr   = 1'b0;
    rx_if.sh  = SH_CTRL;
    rx_if.val = 1'b1;
    rx_if.dat = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    step();
    rx_if.val = 1'b0;
    RXRST_N   = 1'b1;
    slip_pulses = 0;
  endtask

  initial begin
    rx2_if.sh  = SH_CTRL;
    rx2_if.val = 1'b0;
    rx2_if.dat = 64'h0;
    cnt_clr2   = 1'b0;

    // Reset values while reset is held with live input traffic.
    do_reset();
    RXRST_N = 1'b0;
    rx_if.val = 1'b1;
    step();
    check("rst_sync",  rx_sync, 0);
    check("rst_slip",  slip, 0);
    check("rst_oval",  tx_if.val, 0);
    check("rst_odat",  tx_if.dat, 0);
    check("rst_osh",   tx_if.sh, 0);
    check("rst_hdr",   hdr_err_cnt, 0);
    check("rst_loss",  lock_loss_cnt, 0);
    rx_if.val = 1'b0;
    RXRST_N = 1'b1;

    // Clean acquisition: lock visible right after the 64th block.
    good_n(63);
    check("acq_63_sync", rx_sync, 0);
    blk(SH_DATA, 1'b1, 64'h1111_2222_3333_4444);
    check("acq_64_sync", rx_sync, 1);
    check("acq_64_oval", tx_if.val, 0);
    check("acq_slip", slip_pulses, 0);
    blk(SH_CTRL, 1'b1, 64'h0123_4567_89AB_CDEF);
    check("out_val", tx_if.val, 1);
    check("out_dat", tx_if.dat, 64'h0123_4567_89AB_CDEF);
    check("out_sh",  tx_if.sh, SH_CTRL);
    blk(SH_O, 1'b0, 64'h5555_0000_5555_0000);
    check("gap_oval", tx_if.val, 0);
    check("gap_osh",  tx_if.sh, SH_O);
    check("gap_hdr",  hdr_err_cnt, 0);

    // 16 bad headers in one window force unlock.
    do_reset();
    good_n(64);
    bad_n(15);
    check("b15_sync", rx_sync, 1);
    check("b15_hdr",  hdr_err_cnt, 15);
    bad_n(1);
    check("b16_sync", rx_sync, 0);
    check("b16_slip", slip, 1);
    check("b16_loss", lock_loss_cnt, 1);
    check("b16_hdr",  hdr_err_cnt, 16);
    good_n(1);
    check("b16_slip_end", slip, 0);
    check("b16_pulses", slip_pulses, 1);
    cnt_clr = 1'b1;
    blk(SH_CTRL, 1'b0);
    cnt_clr = 1'b0;
    check("clr_hdr",  hdr_err_cnt, 0);
    check("clr_loss", lock_loss_cnt, 0);

    // Bad header in HUNT on block 10, 4 ignored blocks, then a gapped 64-block hunt.
    do_reset();
    good_n(9);
    blk(SH_Z, 1'b1);
    check("hunt_slip", slip, 1);
    bad_n(4);
    check("wt_slip", slip, 0);
    check("wt_pulses", slip_pulses, 1);
    good_n(30);
    for (int i = 0; i < 3; i++) blk(SH_Z, 1'b0);
    good_n(33);
    check("relock_63", rx_sync, 0);
    good_n(1);
    check("relock_64", rx_sync, 1);
    check("relock_pulses", slip_pulses, 1);
    check("relock_hdr", hdr_err_cnt, 0);

    // 15 bad per window for 3 windows, then the 16th on the final block of window 4.
    do_reset();
    good_n(64);
    for (int w = 0; w < 3; w++) begin
      bad_n(15);
      good_n(49);
    end
    check("win3_sync", rx_sync, 1);
    check("win3_hdr",  hdr_err_cnt, 45);
    check("win3_loss", lock_loss_cnt, 0);
    bad_n(15);
    good_n(48);
    check("win4_63_sync", rx_sync, 1);
    bad_n(1);
    check("win4_end_sync", rx_sync, 0);
    check("win4_end_slip", slip, 1);
    check("win4_end_loss", lock_loss_cnt, 1);
    check("win4_end_hdr",  hdr_err_cnt, 61);

    // RX_VAL gaps hold counts; then reset mid-lock.
    do_reset();
    good_n(64);
    good_n(7);
    bad_n(3);
    for (int i = 0; i < 5; i++) blk(SH_O, 1'b0);
    check("hold_hdr",  hdr_err_cnt, 3);
    check("hold_sync", rx_sync, 1);
    bad_n(12);
    check("hold_15_sync", rx_sync, 1);
    bad_n(1);
    check("hold_16_sync", rx_sync, 0);
    check("hold_16_loss", lock_loss_cnt, 1);
    good_n(4);
    good_n(64);
    check("relock2_sync", rx_sync, 1);
    RXRST_N = 1'b0;
    blk(SH_CTRL, 1'b1, 64'h7777);
    check("mid_rst_sync", rx_sync, 0);
    check("mid_rst_oval", tx_if.val, 0);
    check("mid_rst_loss", lock_loss_cnt, 0);
    RXRST_N = 1'b1;
    blk(SH_CTRL, 1'b0);
    check("post_rst_loss", lock_loss_cnt, 0);
    check("slip_width", slip_wide, 0);

    // HDR_ERR_CNT saturation and clear priority on the one-block-window instance.
    rx2_if.sh  = SH_CTRL;
    rx2_if.val = 1'b1;
    step();
    check("sat_lock", rx_sync2, 1);
    rx2_if.sh = SH_O;
    for (int i = 0; i < 65535; i++) step();
    check("sat_ffff", hdr_err_cnt2, 16'hFFFF);
    step();
    check("sat_hold", hdr_err_cnt2, 16'hFFFF);
    check("sat_sync", rx_sync2, 1);
    cnt_clr2 = 1'b1;
    step();
    check("sat_clr", hdr_err_cnt2, 0);
    cnt_clr2 = 1'b0;
    step();
    check("sat_after_clr", hdr_err_cnt2, 1);
    check("sat_loss", lock_loss_cnt2, 0);
    check("sat_slip", slip2, 0);
    rx2_if.val = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
